// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared constants, FSM encoding and key-event type for the
// PS/2 keyboard scan-code sequencer.
package ps2_kbd_pkg;

  // Decode FSM states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_EXT    = 3'd1;
  localparam logic [2:0] ST_BRK    = 3'd2;
  localparam logic [2:0] ST_EXTBRK = 3'd3;
  localparam logic [2:0] ST_PAUSE  = 3'd4;

  // Prefix bytes
  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_E1 = 8'hE1;

  // Bytes following E1 that belong to the Pause sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Bytes the keyboard sends to report an internal error / buffer overrun
  localparam logic [7:0] ERR_B00 = 8'h00;
  localparam logic [7:0] ERR_BFF = 8'hFF;

  localparam int KEY_EVT_W = 10;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } key_evt_t;

  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == ERR_B00) || (b == ERR_BFF);
  endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_fifo.sv
// ps2_kbd_fifo: generic synchronous show-ahead FIFO. The head entry is
// visible on dout whenever empty is low; pop only advances the read pointer.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
//
// Handshake: push is accepted when not full, or when full together with an
// accepted pop (pop is accepted only when not empty). A push that is not
// accepted raises ovf for that cycle.
module ps2_kbd_fifo #(
  parameter int W  = 10,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         res,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         ovf
);

  localparam int DEPTH = 1 << AW;

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  // Accept/reject push and pop, next pointers and storage contents
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    ovf     = push && !do_push;
    wr_d    = wr_q;
    rd_d    = rd_q;
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d                = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (res) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage; contents need no reset because empty masks them
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: folds PS/2 set-2 prefix sequences (E0/F0/E1) into single key
// events {brk, ext, code} and queues them for the CPU.
// Optional feature macro: PS2_KBD_REPEAT_FILTER_EN (drops typematic repeats).
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int PFX_TMO = 255
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ps2_done,
  input  logic [7:0] ps2_out,
  input  logic       tim_clk,
  input  logic       key_pop,
  input  logic       err_clr,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       key_ovf,
  output logic       kbd_err
);

  localparam int TW = $clog2(PFX_TMO + 1);

  logic [2:0]    state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          kbd_err_q, kbd_err_d;
  logic          key_ovf_q, key_ovf_d;

  logic          dec_push;
  key_evt_t      dec_evt;
  logic          err_set;
  logic          fifo_push;
  logic          fifo_empty;
  logic          fifo_full_unused;
  logic          fifo_ovf;
  key_evt_t      fifo_head;

  // Prefix decode FSM and inter-byte timeout
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    tmo_d    = tmo_q;
    dec_push = 1'b0;
    dec_evt  = '0;
    err_set  = 1'b0;
    if ((state_q != ST_IDLE) && (tmo_q == TW'(PFX_TMO))) begin
      // Sequence stalled: abandon it and flag the error
      state_d = ST_IDLE;
      tmo_d   = '0;
      err_set = 1'b1;
    end else begin
      if (ps2_done) begin
        tmo_d = '0;
      end else if (tim_clk && (state_q != ST_IDLE)) begin
        tmo_d = tmo_q + TW'(1);
      end
      if (ps2_done) begin
        case (state_q)
          ST_IDLE: begin
            if (ps2_out == PFX_E0) begin
              state_d = ST_EXT;
            end else if (ps2_out == PFX_F0) begin
              state_d = ST_BRK;
            end else if (ps2_out == PFX_E1) begin
              state_d = ST_PAUSE;
              skip_d  = PAUSE_SKIP;
            end else if (is_err_byte(ps2_out)) begin
              err_set = 1'b1;
            end else begin
              dec_push = 1'b1;
              dec_evt  = '{brk: 1'b0, ext: 1'b0, code: ps2_out};
            end
          end
          ST_EXT: begin
            if (ps2_out == PFX_E0) begin
              state_d = ST_EXT;
            end else if (ps2_out == PFX_F0) begin
              state_d = ST_EXTBRK;
            end else if (is_err_byte(ps2_out)) begin
              err_set = 1'b1;
              state_d = ST_IDLE;
            end else begin
              dec_push = 1'b1;
              dec_evt  = '{brk: 1'b0, ext: 1'b1, code: ps2_out};
              state_d  = ST_IDLE;
            end
          end
          ST_BRK: begin
            if (is_err_byte(ps2_out)) begin
              err_set = 1'b1;
            end else begin
              dec_push = 1'b1;
              dec_evt  = '{brk: 1'b1, ext: 1'b0, code: ps2_out};
            end
            state_d = ST_IDLE;
          end
          ST_EXTBRK: begin
            if (ps2_out == PFX_E0) begin
              state_d = ST_EXTBRK;
            end else if (is_err_byte(ps2_out)) begin
              err_set = 1'b1;
              state_d = ST_IDLE;
            end else begin
              dec_push = 1'b1;
              dec_evt  = '{brk: 1'b1, ext: 1'b1, code: ps2_out};
              state_d  = ST_IDLE;
            end
          end
          ST_PAUSE: begin
            // Pause has no break code; report it once as a make of E1
            if (skip_q == 3'd1) begin
              skip_d   = 3'd0;
              dec_push = 1'b1;
              dec_evt  = '{brk: 1'b0, ext: 1'b0, code: PFX_E1};
              state_d  = ST_IDLE;
            end else begin
              skip_d = skip_q - 3'd1;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef PS2_KBD_REPEAT_FILTER_EN
  logic       rpt_vld_q, rpt_vld_d;
  logic [8:0] rpt_key_q, rpt_key_d;
  logic       rpt_hit;

  // Autorepeat filter: remember the last make, forget it on its break
  always_comb begin
    rpt_vld_d = rpt_vld_q;
    rpt_key_d = rpt_key_q;
    rpt_hit   = rpt_vld_q && (rpt_key_q == {dec_evt.ext, dec_evt.code});
    fifo_push = dec_push && !(!dec_evt.brk && rpt_hit);
    if (dec_push) begin
      if (!dec_evt.brk) begin
        rpt_vld_d = 1'b1;
        rpt_key_d = {dec_evt.ext, dec_evt.code};
      end else if (rpt_hit) begin
        rpt_vld_d = 1'b0;
      end
    end
  end

  // Filter match record
  always_ff @(posedge clk) begin
    if (res) begin
      rpt_vld_q <= 1'b0;
      rpt_key_q <= '0;
    end else begin
      rpt_vld_q <= rpt_vld_d;
      rpt_key_q <= rpt_key_d;
    end
  end
`else
  assign fifo_push = dec_push;
`endif

  // Sticky error flags; a new error outranks a clear in the same cycle
  always_comb begin
    kbd_err_d = kbd_err_q;
    key_ovf_d = key_ovf_q;
    if (err_clr) begin
      kbd_err_d = 1'b0;
      key_ovf_d = 1'b0;
    end
    if (err_set) begin
      kbd_err_d = 1'b1;
    end
    if (fifo_ovf) begin
      key_ovf_d = 1'b1;
    end
  end

  // State, counters and flags
  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= ST_IDLE;
      skip_q    <= '0;
      tmo_q     <= '0;
      kbd_err_q <= 1'b0;
      key_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      tmo_q     <= tmo_d;
      kbd_err_q <= kbd_err_d;
      key_ovf_q <= key_ovf_d;
    end
  end

  // Overflow is taken from the ovf pulse, so full is not needed here
  ps2_kbd_fifo #(
    .W  (KEY_EVT_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (fifo_push),
    .pop   (key_pop),
    .din   (dec_evt),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full_unused),
    .ovf   (fifo_ovf)
  );

  assign key_valid = !fifo_empty;
  assign key_code  = fifo_empty ? 8'h00 : fifo_head.code;
  assign key_ext   = fifo_empty ? 1'b0  : fifo_head.ext;
  assign key_brk   = fifo_empty ? 1'b0  : fifo_head.brk;
  assign key_ovf   = key_ovf_q;
  assign kbd_err   = kbd_err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: directed and randomized byte streams into ps2_kbd_ctrl,
// checked against a flag-based scan-code model and an expected-event queue.
module tb_ps2_kbd_ctrl;

  localparam int FIFO_AW = 3;
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int PFX_TMO = 255;

  logic       clk = 1'b0;
  logic       res;
  logic       ps2_done;
  logic [7:0] ps2_out;
  logic       tim_clk;
  logic       drv_pop;
  logic       mon_pop;
  logic       key_pop;
  logic       err_clr;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;
  logic       key_ovf;
  logic       kbd_err;

  assign key_pop = drv_pop | mon_pop;

  ps2_kbd_ctrl #(
    .FIFO_AW (FIFO_AW),
    .PFX_TMO (PFX_TMO)
  ) dut (
    .clk       (clk),
    .res       (res),
    .ps2_done  (ps2_done),
    .ps2_out   (ps2_out),
    .tim_clk   (tim_clk),
    .key_pop   (key_pop),
    .err_clr   (err_clr),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_brk   (key_brk),
    .key_ovf   (key_ovf),
    .kbd_err   (kbd_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q[$];
  bit         mon_en = 1'b0;

  // reference model: pending prefix flags, remaining Pause bytes, flags
  bit m_ext, m_brk, m_err, m_ovf;
  int m_pause;
`ifdef PS2_KBD_REPEAT_FILTER_EN
  bit         m_rpt_vld;
  logic [8:0] m_rpt;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    m_ext = 1'b0; m_brk = 1'b0; m_pause = 0;
    m_err = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
`ifdef PS2_KBD_REPEAT_FILTER_EN
    m_rpt_vld = 1'b0; m_rpt = '0;
`endif
  endfunction

  // one decoded key event enters the queue if there is room
  function automatic void emit(input bit brk, input bit ext, input logic [7:0] code);
`ifdef PS2_KBD_REPEAT_FILTER_EN
    if (!brk && m_rpt_vld && m_rpt == {ext, code}) return;
    if (!brk) begin
      m_rpt_vld = 1'b1; m_rpt = {ext, code};
    end else if (m_rpt_vld && m_rpt == {ext, code}) begin
      m_rpt_vld = 1'b0;
    end
`endif
    if (exp_q.size() < DEPTH) exp_q.push_back({brk, ext, code});
    else m_ovf = 1'b1;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    bit bad;
    bad = (b == 8'h00) || (b == 8'hFF);
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) emit(1'b0, 1'b0, 8'hE1);
      return;
    end
    if (!m_ext && !m_brk) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE1) m_pause = 7;
      else if (bad) m_err = 1'b1;
      else emit(1'b0, 1'b0, b);
    end else begin
      if (m_ext && b == 8'hE0) return;
      if (m_ext && !m_brk && b == 8'hF0) begin
        m_brk = 1'b1;
        return;
      end
      if (bad) m_err = 1'b1;
      else emit(m_brk, m_ext, b);
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    ps2_out  = b;
    ps2_done = 1'b1;
    model_byte(b);
    @(negedge clk);
    ps2_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    res = 1'b1;
    repeat (2) @(negedge clk);
    res = 1'b0;
    model_clear();
  endtask

  task automatic tim_strobe();
    @(negedge clk);
    tim_clk = 1'b1;
    @(negedge clk);
    tim_clk = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_valid_low"}, key_valid, 1'b0);
  endtask

  // ---------------- monitor: pop and compare head entries ----------------
  initial begin
    logic [9:0] e;
    mon_pop = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mon_pop = 1'b0;
      if (mon_en && key_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_entry: got 0x%0h, expected none", {key_brk, key_ext, key_code});
        end else begin
          e = exp_q.pop_front();
          chk("entry", {key_brk, key_ext, key_code}, e);
        end
        mon_pop = 1'b1;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    int         r;
    res = 1'b1; ps2_done = 1'b0; ps2_out = 8'h00; tim_clk = 1'b0;
    drv_pop = 1'b0; err_clr = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    res = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_code", key_code, 8'h00);
    chk("rst_ext", key_ext, 1'b0);
    chk("rst_brk", key_brk, 1'b0);
    chk("rst_ovf", key_ovf, 1'b0);
    chk("rst_err", kbd_err, 1'b0);
    chk("rst_state", dut.state_q, 3'd0);

    // 1: make then break of 1C, key_valid one cycle after the done
    @(negedge clk);
    chk("t1_valid_before", key_valid, 1'b0);
    ps2_out = 8'h1C; ps2_done = 1'b1;
    model_byte(8'h1C);
    @(posedge clk);
    #1;
    chk("t1_valid_next", key_valid, 1'b1);
    @(negedge clk);
    ps2_done = 1'b0;
    mon_en = 1'b1;
    send_byte(8'hF0, 2);
    send_byte(8'h1C, 2);
    wait_drain("t1");

    // 2: extended break and the Pause sequence
    send_byte(8'hE0, 2); send_byte(8'hF0, 2); send_byte(8'h75, 2);
    send_byte(8'hE1, 2); send_byte(8'h14, 2); send_byte(8'h77, 2); send_byte(8'hE1, 2);
    send_byte(8'hF0, 2); send_byte(8'h14, 2); send_byte(8'hF0, 2); send_byte(8'h77, 2);
    wait_drain("t2");

    // 3: overflow, then push with simultaneous pop while full
    mon_en = 1'b0;
    for (int i = 0; i <= DEPTH; i++) send_byte(8'h10 + 8'(i), 0);
    @(negedge clk);
    chk("t3_ovf", key_ovf, 1'b1);
    chk("t3_head", {key_brk, key_ext, key_code}, 10'h010);
    chk("t3_full", dut.u_fifo.full, 1'b1);
    pulse_err_clr();
    chk("t3_ovf_clr", key_ovf, 1'b0);
    @(negedge clk);
    chk("t3_head_before_pp", {key_brk, key_ext, key_code}, exp_q[0]);
    ps2_out = 8'h20; ps2_done = 1'b1; drv_pop = 1'b1;
    void'(exp_q.pop_front());
    model_byte(8'h20);
    @(negedge clk);
    ps2_done = 1'b0; drv_pop = 1'b0;
    chk("t3_ovf_after_pp", key_ovf, 1'b0);
    chk("t3_still_full", dut.u_fifo.full, 1'b1);
    chk("t3_model_size", exp_q.size(), DEPTH);
    mon_en = 1'b1;
    wait_drain("t3");

    // 4: sequence timeout after E0
    chk("t4_err_before", kbd_err, 1'b0);
    send_byte(8'hE0, 1);
    for (int i = 0; i < PFX_TMO - 1; i++) tim_strobe();
    @(negedge clk);
    chk("t4_err_early", kbd_err, 1'b0);
    chk("t4_busy", dut.state_q != 3'd0, 1'b1);
    tim_strobe();
    @(negedge clk);
    chk("t4_err", kbd_err, 1'b1);
    chk("t4_idle", dut.state_q, 3'd0);
    m_ext = 1'b0; m_brk = 1'b0; m_err = 1'b1;
    send_byte(8'h1C, 2);
    wait_drain("t4");

    // 5: error byte, clear, set-wins, reset mid-sequence
    pulse_err_clr();
    chk("t5_err_clr", kbd_err, 1'b0);
    send_byte(8'hFF, 2);
    chk("t5_err_ff", kbd_err, 1'b1);
    pulse_err_clr();
    chk("t5_err_clr2", kbd_err, 1'b0);
    @(negedge clk);
    ps2_out = 8'h00; ps2_done = 1'b1; err_clr = 1'b1;
    model_byte(8'h00);
    @(negedge clk);
    ps2_done = 1'b0; err_clr = 1'b0;
    chk("t5_set_wins", kbd_err, 1'b1);
    send_byte(8'hF0, 2);
    do_reset();
    chk("t5_err_after_rst", kbd_err, 1'b0);
    send_byte(8'h1C, 2);
    wait_drain("t5");

    // 6: typematic repeat stream
    send_byte(8'h1C, 2); send_byte(8'h1C, 2); send_byte(8'h1C, 2);
    send_byte(8'hF0, 2); send_byte(8'h1C, 2); send_byte(8'h1C, 2);
    wait_drain("t6");

    // random byte stream
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) b = 8'hE0;
      else if (r < 20) b = 8'hF0;
      else if (r < 23) b = 8'hE1;
      else if (r < 25) b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      else b = 8'($urandom_range(1, 254));
      send_byte(b, $urandom_range(2, 5));
    end
    wait_drain("rnd");
    chk("rnd_err", kbd_err, m_err);
    chk("rnd_ovf", key_ovf, m_ovf);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
